// File: rtl/in2post_arbiter.sv
// Round-robin arbiter sharing one infix-to-postfix converter between two
// requesters; owner holds the converter until its postfix burst completes.
module in2post_arbiter #(
  parameter int unsigned DATA_BIT      = 6,
  parameter int unsigned MAX_TOKENS    = 32,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ0,
  input  logic                REQ1,
  output logic                GNT0,
  output logic                GNT1,
  input  logic [DATA_BIT-1:0] IN0,
  input  logic [DATA_BIT-1:0] IN1,
  input  logic                IN0_VALID,
  input  logic                IN1_VALID,
  input  logic                OP0_VALID,
  input  logic                OP1_VALID,
  output logic [DATA_BIT-1:0] CONV_IN,
  output logic                CONV_IN_VALID,
  output logic                CONV_OP_VALID,
  input  logic [DATA_BIT-1:0] CONV_OUT,
  input  logic                CONV_OUT_VALID,
  output logic [DATA_BIT-1:0] RES_OUT,
  output logic                RES_OUT_VALID,
  output logic                RES_ID,
  output logic                BUSY,
  output logic                ERR
);

  localparam int unsigned CNT_W = $clog2(MAX_TOKENS + 2);
  localparam int unsigned WD_W  = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GRANT, FEED, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic                pri_q, pri_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    tok_cnt_q, tok_cnt_d;
  logic                out_seen_q, out_seen_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [DATA_BIT-1:0] conv_in_q, conv_in_d;
  logic                conv_in_valid_q, conv_in_valid_d;
  logic                conv_op_valid_q, conv_op_valid_d;
  logic [DATA_BIT-1:0] res_out_q, res_out_d;
  logic                res_out_valid_q, res_out_valid_d;
  logic                res_id_q, res_id_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // Owner-selected requester view; the other channel is ignored entirely.
  logic                sel_req_c, sel_vld_c, sel_op_c;
  logic [DATA_BIT-1:0] sel_in_c;

  assign sel_req_c = owner_q ? REQ1      : REQ0;
  assign sel_vld_c = owner_q ? IN1_VALID : IN0_VALID;
  assign sel_op_c  = owner_q ? OP1_VALID : OP0_VALID;
  assign sel_in_c  = owner_q ? IN1       : IN0;

  always_comb begin
    state_d         = state_q;
    pri_d           = pri_q;
    owner_d         = owner_q;
    tok_cnt_d       = tok_cnt_q;
    out_seen_d      = out_seen_q;
    wdog_d          = wdog_q;
    gnt0_d          = gnt0_q;
    gnt1_d          = gnt1_q;
    conv_in_d       = conv_in_q;
    conv_in_valid_d = 1'b0;
    conv_op_valid_d = 1'b0;
    err_d           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pri_q ? REQ1 : REQ0) begin
          owner_d = pri_q;
          state_d = GRANT;
        end else if (pri_q ? REQ0 : REQ1) begin
          owner_d = ~pri_q;
          state_d = GRANT;
        end
        if (state_d == GRANT) begin
          gnt0_d = ~owner_d;
          gnt1_d = owner_d;
        end
      end
      GRANT: begin
        if (sel_vld_c) begin
          state_d         = FEED;
          conv_in_d       = sel_in_c;
          conv_in_valid_d = 1'b1;
          conv_op_valid_d = sel_op_c;
          tok_cnt_d       = CNT_W'(1);
        end else if (!sel_req_c) begin
          state_d = IDLE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end
      end
      FEED: begin
        conv_in_d = sel_in_c;
        if (CONV_OUT_VALID) out_seen_d = 1'b1;
        if (sel_vld_c) begin
          // Tokens past MAX_TOKENS are swallowed; counter saturates so ERR fires once.
          if (tok_cnt_q < CNT_W'(MAX_TOKENS)) begin
            conv_in_valid_d = 1'b1;
            conv_op_valid_d = sel_op_c;
          end else if (tok_cnt_q == CNT_W'(MAX_TOKENS)) begin
            err_d = 1'b1;
          end
          if (tok_cnt_q <= CNT_W'(MAX_TOKENS)) tok_cnt_d = tok_cnt_q + CNT_W'(1);
        end else begin
          state_d = DRAIN;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          wdog_d  = '0;
        end
      end
      DRAIN: begin
        if (CONV_OUT_VALID) out_seen_d = 1'b1;
        if (out_seen_q && !CONV_OUT_VALID) begin
          state_d = DONE;
        end else if (!out_seen_q && !CONV_OUT_VALID) begin
          if (wdog_q == WD_W'(DRAIN_TIMEOUT - 1)) begin
            wdog_d  = WD_W'(DRAIN_TIMEOUT);
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
      end
      DONE: begin
        pri_d      = ~owner_q;
        tok_cnt_d  = '0;
        out_seen_d = 1'b0;
        wdog_d     = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    res_out_d       = CONV_OUT;
    res_out_valid_d = CONV_OUT_VALID && ((state_q == FEED) || (state_q == DRAIN));
    res_id_d        = owner_q;
    busy_d          = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= IDLE;
      pri_q           <= 1'b0;
      owner_q         <= 1'b0;
      tok_cnt_q       <= '0;
      out_seen_q      <= 1'b0;
      wdog_q          <= '0;
      gnt0_q          <= 1'b0;
      gnt1_q          <= 1'b0;
      conv_in_q       <= '0;
      conv_in_valid_q <= 1'b0;
      conv_op_valid_q <= 1'b0;
      res_out_q       <= '0;
      res_out_valid_q <= 1'b0;
      res_id_q        <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      pri_q           <= pri_d;
      owner_q         <= owner_d;
      tok_cnt_q       <= tok_cnt_d;
      out_seen_q      <= out_seen_d;
      wdog_q          <= wdog_d;
      gnt0_q          <= gnt0_d;
      gnt1_q          <= gnt1_d;
      conv_in_q       <= conv_in_d;
      conv_in_valid_q <= conv_in_valid_d;
      conv_op_valid_q <= conv_op_valid_d;
      res_out_q       <= res_out_d;
      res_out_valid_q <= res_out_valid_d;
      res_id_q        <= res_id_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
    end
  end

  assign GNT0          = gnt0_q;
  assign GNT1          = gnt1_q;
  assign CONV_IN       = conv_in_q;
  assign CONV_IN_VALID = conv_in_valid_q;
  assign CONV_OP_VALID = conv_op_valid_q;
  assign RES_OUT       = res_out_q;
  assign RES_OUT_VALID = res_out_valid_q;
  assign RES_ID        = res_id_q;
  assign BUSY          = busy_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_in2post_arbiter.sv
// Directed bench for in2post_arbiter: single request, contention, abandoned
// grant, overflow, drain timeout and asynchronous reset.
module tb_in2post_arbiter;

  logic       CLK, RESET;
  logic       REQ0, REQ1, GNT0, GNT1;
  logic [5:0] IN0, IN1;
  logic       IN0_VALID, IN1_VALID, OP0_VALID, OP1_VALID;
  logic [5:0] CONV_IN;
  logic       CONV_IN_VALID, CONV_OP_VALID;
  logic [5:0] CONV_OUT;
  logic       CONV_OUT_VALID;
  logic [5:0] RES_OUT;
  logic       RES_OUT_VALID, RES_ID, BUSY, ERR;

  int checks   = 0;
  int failures = 0;

  logic [5:0] tok_v  [8];
  logic       tok_op [8];
  logic [5:0] out_v  [8];

  in2post_arbiter #(.DATA_BIT(6), .MAX_TOKENS(32), .DRAIN_TIMEOUT(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .GNT0(GNT0), .GNT1(GNT1),
    .IN0(IN0), .IN1(IN1),
    .IN0_VALID(IN0_VALID), .IN1_VALID(IN1_VALID),
    .OP0_VALID(OP0_VALID), .OP1_VALID(OP1_VALID),
    .CONV_IN(CONV_IN), .CONV_IN_VALID(CONV_IN_VALID), .CONV_OP_VALID(CONV_OP_VALID),
    .CONV_OUT(CONV_OUT), .CONV_OUT_VALID(CONV_OUT_VALID),
    .RES_OUT(RES_OUT), .RES_OUT_VALID(RES_OUT_VALID), .RES_ID(RES_ID),
    .BUSY(BUSY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    chk1("gnt_onehot", GNT0 & GNT1, 1'b0);
  endtask

  function automatic logic gnt_of(input logic ch);
    return ch ? GNT1 : GNT0;
  endfunction

  task automatic set_req(input logic ch, input logic v);
    if (ch) REQ1 = v; else REQ0 = v;
  endtask

  task automatic set_in(input logic ch, input logic [5:0] d, input logic v, input logic op);
    if (ch) begin IN1 = d; IN1_VALID = v; OP1_VALID = op; end
    else    begin IN0 = d; IN0_VALID = v; OP0_VALID = op; end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    REQ0 = 0; REQ1 = 0;
    IN0 = 0; IN1 = 0; IN0_VALID = 0; IN1_VALID = 0; OP0_VALID = 0; OP1_VALID = 0;
    CONV_OUT = 0; CONV_OUT_VALID = 0;
    tick(); tick();
    RESET = 1'b1;
  endtask

  // Feed ntok tokens from ch (already in GRANT), then return nout results.
  task automatic run_expr(input logic ch, input int ntok, input int nout, input logic drop);
    for (int i = 0; i < ntok; i++) begin
      set_in(ch, tok_v[i], 1'b1, tok_op[i]);
      set_in(~ch, 6'h3F, 1'b1, 1'b1);
      tick();
      chk6("conv_in", CONV_IN, tok_v[i]);
      chk1("conv_in_valid", CONV_IN_VALID, 1'b1);
      chk1("conv_op_valid", CONV_OP_VALID, tok_op[i]);
      chk1("gnt_held", gnt_of(ch), 1'b1);
    end
    set_in(ch, 6'd0, 1'b0, 1'b0);
    set_in(~ch, 6'd0, 1'b0, 1'b0);
    if (drop) set_req(ch, 1'b0);
    tick();
    chk1("drain_conv_in_valid", CONV_IN_VALID, 1'b0);
    chk1("drain_gnt_clear", gnt_of(ch), 1'b0);
    chk1("drain_busy", BUSY, 1'b1);
    for (int j = 0; j < nout; j++) begin
      CONV_OUT = out_v[j];
      CONV_OUT_VALID = 1'b1;
      tick();
      chk6("res_out", RES_OUT, out_v[j]);
      chk1("res_out_valid", RES_OUT_VALID, 1'b1);
      chk1("res_id", RES_ID, ch);
    end
    CONV_OUT_VALID = 1'b0;
    tick();
    chk1("done_res_valid", RES_OUT_VALID, 1'b0);
    chk1("done_busy", BUSY, 1'b1);
    tick();
    chk1("idle_busy", BUSY, 1'b0);
    chk1("idle_err", ERR, 1'b0);
  endtask

  int n_valid, n_err;

  initial begin
    tok_v  = '{6'd3, 6'd43, 6'd4, 6'd42, 6'd5, 6'd0, 6'd0, 6'd0};
    tok_op = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    out_v  = '{6'd3, 6'd4, 6'd5, 6'd42, 6'd43, 6'd0, 6'd0, 6'd0};

    // Reset state
    do_reset();
    chk1("rst_gnt0", GNT0, 1'b0);
    chk1("rst_gnt1", GNT1, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_err", ERR, 1'b0);
    chk1("rst_conv_in_valid", CONV_IN_VALID, 1'b0);
    chk1("rst_res_valid", RES_OUT_VALID, 1'b0);

    // Single request: 3 + 4 * 5 -> 3 4 5 * +
    REQ0 = 1'b1;
    tick();
    chk1("single_gnt0", GNT0, 1'b1);
    chk1("single_busy", BUSY, 1'b1);
    tick();
    chk1("single_gnt0_wait", GNT0, 1'b1);
    chk1("single_no_tok", CONV_IN_VALID, 1'b0);
    run_expr(1'b0, 5, 5, 1'b1);
    // PRI now 1: both requesting grants ch1
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    chk1("pri1_gnt1", GNT1, 1'b1);
    chk1("pri1_gnt0", GNT0, 1'b0);
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    chk1("pri1_abandon", GNT1, 1'b0);

    // Contention from reset: ch0, ch1, ch0, ch1
    do_reset();
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    chk1("cont1_gnt0", GNT0, 1'b1);
    run_expr(1'b0, 3, 3, 1'b0);
    tick();
    chk1("cont2_gnt1", GNT1, 1'b1);
    run_expr(1'b1, 5, 2, 1'b0);
    tick();
    chk1("cont3_gnt0", GNT0, 1'b1);
    run_expr(1'b0, 2, 4, 1'b1);
    tick();
    chk1("cont4_gnt1", GNT1, 1'b1);
    run_expr(1'b1, 4, 1, 1'b1);

    // Abandoned grant on ch1
    do_reset();
    REQ1 = 1'b1;
    tick();
    chk1("ab_gnt1", GNT1, 1'b1);
    tick();
    chk1("ab_gnt1_hold", GNT1, 1'b1);
    REQ1 = 1'b0;
    tick();
    chk1("ab_gnt1_fall", GNT1, 1'b0);
    chk1("ab_busy", BUSY, 1'b0);
    chk1("ab_err", ERR, 1'b0);
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    chk1("ab_pri0_gnt0", GNT0, 1'b1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    chk1("ab_pri0_release", GNT0, 1'b0);

    // Overflow: 35 contiguous tokens on ch0
    do_reset();
    REQ0 = 1'b1;
    tick();
    chk1("ovf_gnt0", GNT0, 1'b1);
    n_valid = 0; n_err = 0;
    for (int i = 0; i < 35; i++) begin
      set_in(1'b0, 6'(i), 1'b1, 1'b0);
      tick();
      if (CONV_IN_VALID) n_valid++;
      if (ERR) n_err++;
      chk1("ovf_valid", CONV_IN_VALID, i < 32);
      chk1("ovf_err", ERR, i == 32);
      if (i < 32) chk6("ovf_conv_in", CONV_IN, 6'(i));
    end
    set_in(1'b0, 6'd0, 1'b0, 1'b0);
    REQ0 = 1'b0;
    tick();
    chkn("ovf_total_valid", n_valid, 32);
    chkn("ovf_total_err", n_err, 1);
    chk1("ovf_drain_gnt", GNT0, 1'b0);
    CONV_OUT = 6'd7; CONV_OUT_VALID = 1'b1;
    tick();
    chk6("ovf_res_out", RES_OUT, 6'd7);
    CONV_OUT_VALID = 1'b0;
    tick(); tick();
    chk1("ovf_idle", BUSY, 1'b0);

    // Timeout: PRI=1 after ch0 finished; ch1 expression with no converter output
    REQ1 = 1'b1;
    tick();
    chk1("to_gnt1", GNT1, 1'b1);
    set_in(1'b1, 6'd9, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 6'd0, 1'b0, 1'b0);
    REQ1 = 1'b0;
    tick();
    chk1("to_drain_gnt", GNT1, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk1("to_err", ERR, k == 64);
    end
    chk1("to_done_busy", BUSY, 1'b1);
    tick();
    chk1("to_idle_busy", BUSY, 1'b0);
    chk1("to_err_clear", ERR, 1'b0);
    REQ0 = 1'b1;
    tick();
    chk1("to_next_gnt0", GNT0, 1'b1);

    // Async reset mid-FEED with a result in flight
    set_in(1'b0, 6'd5, 1'b1, 1'b0);
    tick();
    CONV_OUT = 6'd5; CONV_OUT_VALID = 1'b1;
    tick();
    chk1("ar_pre_gnt0", GNT0, 1'b1);
    chk1("ar_pre_civ", CONV_IN_VALID, 1'b1);
    chk1("ar_pre_rov", RES_OUT_VALID, 1'b1);
    chk1("ar_pre_busy", BUSY, 1'b1);
    #2;
    RESET = 1'b0;
    #1;
    chk1("ar_gnt0", GNT0, 1'b0);
    chk1("ar_civ", CONV_IN_VALID, 1'b0);
    chk1("ar_rov", RES_OUT_VALID, 1'b0);
    chk1("ar_busy", BUSY, 1'b0);
    chk1("ar_err", ERR, 1'b0);
    REQ0 = 0; CONV_OUT_VALID = 0;
    set_in(1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    #2;
    RESET = 1'b1;
    REQ1 = 1'b1;
    tick();
    chk1("ar_req1_gnt1", GNT1, 1'b1);
    REQ1 = 1'b0;
    tick();
    chk1("ar_req1_release", GNT1, 1'b0);
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    chk1("ar_pri0_gnt0", GNT0, 1'b1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in2post_arbiter.md
Name: in2post_arbiter

Overview:
- Shares one infix-to-postfix converter between two expression requesters (ch0, ch1).
- Grants the converter to one requester per expression using round-robin priority.
- Forwards the winner's token stream to the converter, then holds ownership until the converter's postfix output burst completes.
- Returns converter output tagged with the owner ID. Sits between the requesters and the converter's IN/IN_VALID/OP_VALID and OUT/OUT_VALID ports.

Parameters:
- DATA_BIT, 6, token/data width (IN, CONV_IN, CONV_OUT, RES_OUT).
- MAX_TOKENS, 32, maximum tokens per expression; converter stack depth is 2^5.
- DRAIN_TIMEOUT, 64, cycles allowed in DRAIN before the first CONV_OUT_VALID.

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- REQ0, REQ1  in  1  requester wants converter; held until its expression is sent
- GNT0, GNT1  out  1  grant, one-hot or zero
- IN0, IN1  in  DATA_BIT  requester token
- IN0_VALID, IN1_VALID  in  1  token valid; contiguous high for one expression
- OP0_VALID, OP1_VALID  in  1  token is an operator/parenthesis (qualified by INx_VALID)
- CONV_IN  out  DATA_BIT  token to converter
- CONV_IN_VALID  out  1  to converter IN_VALID
- CONV_OP_VALID  out  1  to converter OP_VALID
- CONV_OUT  in  DATA_BIT  converter OUT
- CONV_OUT_VALID  in  1  converter OUT_VALID
- RES_OUT  out  DATA_BIT  forwarded postfix token
- RES_OUT_VALID  out  1  RES_OUT valid
- RES_ID  out  1  owner of RES_OUT (0=ch0, 1=ch1)
- BUSY  out  1  state != IDLE
- ERR  out  1  one-cycle error pulse

Behaviour:
- Reset (RESET=0, async): state IDLE, PRI=0, owner=0, all outputs 0, counters 0, out_seen=0.

State machine (registered outputs):
- IDLE
  - If REQ[PRI] is high: owner=PRI. Else if REQ[~PRI] is high: owner=~PRI.
  - On a grant, go to GRANT; GNT[owner]=1 in the next cycle (REQ->GNT latency 1 cycle). No request: stay in IDLE.
- GRANT
  - GNT held.
  - If IN[owner]_VALID=1: go to FEED; this token is forwarded.
  - If REQ[owner] drops with no token: go to IDLE; GNT cleared; PRI unchanged.
- FEED
  - Each cycle: CONV_IN<=IN[owner]; CONV_IN_VALID<=IN[owner]_VALID; CONV_OP_VALID<=OP[owner]_VALID & IN[owner]_VALID. Forwarding latency is 1 cycle.
  - tok_cnt increments per token.
  - Token number MAX_TOKENS+1 and beyond: not forwarded (CONV_IN_VALID=0); ERR pulses once per expression.
  - First cycle with IN[owner]_VALID=0: go to DRAIN; GNT cleared the same edge.
- DRAIN
  - Waits for converter output.
  - out_seen is set by any CONV_OUT_VALID observed in FEED or DRAIN.
  - Exit to DONE on the first cycle with out_seen=1 and CONV_OUT_VALID=0.
  - Watchdog counts from DRAIN entry while out_seen=0. If it reaches DRAIN_TIMEOUT: ERR pulses and the state goes to DONE. The watchdog freezes once out_seen=1.
- DONE
  - Lasts 1 cycle: PRI<=~owner; tok_cnt, out_seen and watchdog cleared; next state IDLE.
  - A request pending at DONE is granted no earlier than 2 cycles later (DONE->IDLE->GRANT).

Rules:
- The non-owner's IN/VALID/OP are ignored; the non-owner's REQ may be held indefinitely.
- Both REQ high in IDLE: PRI wins. Alternation is guaranteed under continuous contention.
- Result path: RES_OUT<=CONV_OUT; RES_OUT_VALID<=CONV_OUT_VALID when state is FEED or DRAIN, else 0; RES_ID<=owner. Latency is 1 cycle.
- CONV_OUT_VALID in IDLE, GRANT or DONE is dropped silently.
- REQ[owner] dropping during FEED/DRAIN has no effect; the expression completes.
- Reset asserted mid-operation: immediate return to reset values. Any partial expression is abandoned; the converter is reset externally.

Test Plan:
- Single request:
  - Stimulus: REQ0 at t0; t2..t6 ch0 sends 3,+,4,*,5 (OP_VALID on + and *); converter returns 3,4,5,*,+ then OUT_VALID low.
  - Required: GNT0 at t1; CONV_IN mirrors the tokens 1 cycle late; RES_OUT = 3 4 5 * + with RES_ID=0; BUSY low after DONE; PRI=1.
- Contention:
  - Stimulus: REQ0 and REQ1 high from reset, each sends 2 expressions.
  - Required: grant order ch0, ch1, ch0, ch1; GNT never both high; all RES_ID tags match the owner.
- Abandoned grant:
  - Stimulus: REQ1 granted, then dropped after 2 cycles with no token.
  - Required: GNT1 falls, state returns to IDLE, PRI unchanged (0 after reset), ERR stays 0.
- Overflow:
  - Stimulus: 35 contiguous tokens on ch0.
  - Required: exactly 32 CONV_IN_VALID cycles; ERR pulses once, on token 33.
- Timeout:
  - Stimulus: expression fed, converter never raises OUT_VALID.
  - Required: ERR pulse exactly DRAIN_TIMEOUT=64 cycles after DRAIN entry; DONE then IDLE; the next request is granted normally.
- Async reset:
  - Stimulus: RESET=0 mid-FEED, between clock edges.
  - Required: GNT, CONV_IN_VALID, RES_OUT_VALID, BUSY and ERR go 0 immediately; after release, REQ1 alone is granted in 1 cycle with PRI=0.
